key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles a raw key level must hold before it is accepted; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 5: idle cycles enforced after each emitted pulse before the next press is accepted; legal range 1..65535.
REQ-003 Port clock  input  1  single system clock; all state is on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port KEY_N  input  4  raw pushbutton levels, active-low (0 = pressed), asynchronous to clock, may bounce.
REQ-006 Port KEY  output  4  registered one-hot key-press strobe, one clock wide, feeding the lock FSM's KEY input.
REQ-007 Port BUSY  output  1  registered; high while a strobe is being issued or the gap is running.
REQ-008 Port MULTI  output  1  registered one-cycle strobe; a press was rejected because more than one key was involved.

Function
REQ-009 Each KEY_N bit shall pass through a two-flop synchronizer; synchronizer flops shall reset to 1 (released).
REQ-010 Each bit shall have a debounced level register (reset 1) and a counter that clears whenever the synchronized level equals the debounced level.
REQ-011 The counter shall increment each cycle the levels differ; the debounced level shall take the synchronized level on the cycle the count reaches DEBOUNCE_CYCLES, and the counter shall clear.
REQ-012 Counter width shall be ceil(log2(DEBOUNCE_CYCLES+1)); it shall never wrap.
REQ-013 A press event on bit i shall be a debounced 1->0 transition; release transitions (0->1) shall produce no output.
REQ-014 FSM states: IDLE, GAP. Reset state: IDLE.
REQ-015 IDLE, exactly one press event, no other debounced level pressed -> KEY = that one-hot bit for one cycle; go to GAP.
REQ-016 IDLE, two or more simultaneous press events, or one press event while another key is already debounced-pressed -> KEY stays 0; MULTI = 1 for one cycle; stay in IDLE.
REQ-017 GAP shall last exactly GAP_CYCLES cycles after the strobe cycle, then return to IDLE; press events during GAP shall be discarded, not queued.
REQ-018 BUSY shall be 1 in the strobe cycle and in all GAP cycles, otherwise 0.
REQ-019 Latency: with KEY_N[i] low from first sampling edge E1, clean, KEY[i] shall be high during the cycle after edge E(DEBOUNCE_CYCLES+3).
REQ-020 A level change shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no strobe and leave the debounced level unchanged.
REQ-021 A key held continuously shall produce exactly one strobe; a new strobe requires a debounced release then a debounced press.
REQ-022 KEY shall never have more than one bit set, and KEY and MULTI shall never both be nonzero in the same cycle.

Reset
REQ-023 reset low shall immediately force KEY = 0, BUSY = 0, MULTI = 0, FSM = IDLE, all counters 0, synchronizers and debounced levels = 1.
REQ-024 Reset asserted mid-GAP or mid-debounce shall abandon that operation; no strobe shall be emitted from pre-reset activity.
REQ-025 A key held low across reset deassertion shall be treated as a new press and strobe DEBOUNCE_CYCLES+3 edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=5)
REQ-026 Clean press KEY_N=1110 held 20 cycles -> KEY=0001 for exactly one cycle, 7 edges after the first sampling edge; BUSY high 6 cycles; no further strobe until release.
REQ-027 Bounce: KEY_N[3] low 3 cycles, high 1 cycle, low 3 cycles, then high -> KEY stays 0000, MULTI stays 0.
REQ-028 Sequence 0111, 1011, 1101, 1110, each held 8 cycles with 8 released cycles between -> KEY strobes 1000, 0100, 0010, 0001 in order, one each.
REQ-029 KEY_N=1010 applied in the same cycle -> MULTI one-cycle pulse, KEY stays 0000, BUSY stays 0.
REQ-030 Second key pressed so its press event lands in GAP -> no strobe for it; after release and re-press outside GAP -> one strobe.
REQ-031 reset pulled low 2 cycles after a press is debounced (mid-GAP) -> KEY, BUSY, MULTI 0 immediately; after reset high with key still held -> one strobe 7 edges later.

Source files
------------

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Turns four raw, bouncing, active-low pushbuttons into a clean one-hot
//   press strobe for the lock FSM. Each key is synchronized and debounced
//   separately. A small IDLE/GAP FSM then emits one strobe per accepted press
//   and enforces a quiet gap afterwards.
//
// Parameters
//   DEBOUNCE_CYCLES : synchronized cycles a new level must hold (1..65535)
//   GAP_CYCLES      : idle cycles enforced after each strobe (1..65535)
//
// Ports
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   KEY_N  : raw key levels, 0 = pressed, asynchronous to clock
//   KEY    : registered one-hot press strobe, one cycle wide
//   BUSY   : registered, high during the strobe cycle and the gap
//   MULTI  : registered one-cycle strobe, press rejected (several keys)

module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] KEY_N,
  output logic [3:0] KEY,
  output logic       BUSY,
  output logic       MULTI
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

  typedef enum logic {IDLE, GAP} state_t;

  logic [3:0]    sync1, sync2;
  logic [3:0]    deb_level;
  logic [3:0]    deb_prev;
  logic [3:0]    press;
  logic [3:0]    others_held;
  logic          single_press;
  state_t        state, next_state;
  logic [GW-1:0] gap_cnt, next_gap;
  logic [3:0]    next_key;
  logic          next_busy, next_multi;

  // Two-flop synchronizer; resets to "released" so nothing looks pressed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= KEY_N;
      sync2 <= sync1;
    end
  end

  // Per-key debouncer. The counter only runs while the synchronized level
  // disagrees with the accepted level. It is cleared on acceptance, so it never
  // reaches a value that could wrap.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          lvl;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign deb_level[i] = lvl;
  end

  // Previous debounced level. A press event is an accepted 1->0 edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_prev <= 4'hF;
    end else begin
      deb_prev <= deb_level;
    end
  end

  assign press        = deb_prev & ~deb_level;
  assign others_held  = ~deb_level & ~press;
  assign single_press = (press != 4'h0) && ((press & (press - 4'd1)) == 4'h0);

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      KEY     <= 4'h0;
      BUSY    <= 1'b0;
      MULTI   <= 1'b0;
    end else begin
      state   <= next_state;
      gap_cnt <= next_gap;
      KEY     <= next_key;
      BUSY    <= next_busy;
      MULTI   <= next_multi;
    end
  end

  // Next-state and output decode. Presses seen in GAP are simply dropped,
  // because a press event lasts only one cycle.
  always_comb begin
    next_state = state;
    next_gap   = gap_cnt;
    next_key   = 4'h0;
    next_busy  = 1'b0;
    next_multi = 1'b0;
    case (state)
      IDLE: begin
        if (press != 4'h0) begin
          if (single_press && (others_held == 4'h0)) begin
            next_key   = press;
            next_busy  = 1'b1;
            next_gap   = '0;
            next_state = GAP;
          end else begin
            next_multi = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_gap   = '0;
          next_state = IDLE;
        end else begin
          next_busy = 1'b1;
          next_gap  = gap_cnt + GW'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen
//   Directed bench for key_pulse_gen with DEBOUNCE_CYCLES=4 and GAP_CYCLES=5.
//   Inputs change on the falling edge. Outputs are sampled on the falling edge
//   that follows each rising edge, so after n steps we observe the cycle after
//   edge En.

module tb_key_pulse_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] KEY_N = 4'hF;
  logic [3:0] KEY;
  logic       BUSY;
  logic       MULTI;

  int checks = 0;
  int errors = 0;

  key_pulse_gen #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(5)) dut (
    .clock(clock),
    .reset(reset),
    .KEY_N(KEY_N),
    .KEY(KEY),
    .BUSY(BUSY),
    .MULTI(MULTI)
  );

  always #5 clock = ~clock;

  // One comparison: count it, and on a miss count and report it.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    KEY_N = v;
  endtask

  // Advance one cycle and check that KEY is at most one-hot and exclusive with MULTI.
  task automatic step();
    logic ok;
    @(posedge clock);
    @(negedge clock);
    ok = ($countones(KEY) <= 1) && !((KEY != 4'h0) && MULTI);
    checkBit("excl", ok, 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps during which no strobe and no MULTI may appear.
  task automatic quietSteps(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput(tag, KEY, 4'h0);
      checkBit(tag, MULTI, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] expKey;
    logic [3:0] seen;
    int         strobes;

    // Reset state, checked while reset is still low.
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_key", KEY, 4'h0);
    checkBit("rst_busy", BUSY, 1'b0);
    checkBit("rst_multi", MULTI, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    quietSteps("idle", 3);

    // Clean press of key 0: strobe after E7, BUSY for 6 cycles, then nothing.
    applyStimulus(4'b1110);
    steps(6);
    checkOutput("clean_early", KEY, 4'h0);
    checkBit("clean_early_busy", BUSY, 1'b0);
    step();
    checkOutput("clean_key", KEY, 4'b0001);
    checkBit("clean_busy", BUSY, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("clean_gap_key", KEY, 4'h0);
      checkBit("clean_gap_busy", BUSY, 1'b1);
    end
    step();
    checkBit("clean_busy_end", BUSY, 1'b0);
    quietSteps("clean_hold", 8);
    applyStimulus(4'hF);
    quietSteps("clean_release", 10);
    checkBit("clean_release_busy", BUSY, 1'b0);

    // Bounce on key 3: low 3, high 1, low 3, high. No event may result.
    applyStimulus(4'b0111);
    quietSteps("bounce", 3);
    applyStimulus(4'b1111);
    quietSteps("bounce", 1);
    applyStimulus(4'b0111);
    quietSteps("bounce", 3);
    applyStimulus(4'b1111);
    quietSteps("bounce", 12);

    // Keys 3..0 in turn: 8 cycles held, 8 cycles released, one strobe each.
    for (int j = 3; j >= 0; j--) begin
      pat = 4'hF;
      pat[j] = 1'b0;
      expKey = 4'h0;
      expKey[j] = 1'b1;
      strobes = 0;
      seen = 4'h0;
      applyStimulus(pat);
      for (int c = 0; c < 16; c++) begin
        if (c == 8) applyStimulus(4'hF);
        step();
        checkBit("seq_multi", MULTI, 1'b0);
        if (KEY != 4'h0) begin
          strobes++;
          seen = KEY;
        end
      end
      checkOutput("seq_count", 4'(strobes), 4'd1);
      checkOutput("seq_key", seen, expKey);
    end

    // Two keys pressed together: MULTI only.
    applyStimulus(4'b1010);
    steps(6);
    checkBit("multi_early", MULTI, 1'b0);
    step();
    checkBit("multi_pulse", MULTI, 1'b1);
    checkOutput("multi_key", KEY, 4'h0);
    checkBit("multi_busy", BUSY, 1'b0);
    step();
    checkBit("multi_end", MULTI, 1'b0);
    checkBit("multi_end_busy", BUSY, 1'b0);
    applyStimulus(4'hF);
    quietSteps("multi_release", 10);

    // A second key pressed while the first is still held: MULTI.
    applyStimulus(4'b1110);
    steps(7);
    checkOutput("held_first", KEY, 4'b0001);
    steps(8);
    applyStimulus(4'b1100);
    steps(6);
    checkBit("held_early", MULTI, 1'b0);
    step();
    checkBit("held_multi", MULTI, 1'b1);
    checkOutput("held_key", KEY, 4'h0);
    applyStimulus(4'hF);
    quietSteps("held_release", 10);

    // Key 1 press event falls inside the gap of key 0 and is discarded.
    applyStimulus(4'b1110);
    steps(2);
    applyStimulus(4'b1100);
    strobes = 0;
    seen = 4'h0;
    for (int c = 0; c < 14; c++) begin
      step();
      checkBit("gap_multi", MULTI, 1'b0);
      if (KEY != 4'h0) begin
        strobes++;
        seen = KEY;
      end
    end
    checkOutput("gap_count", 4'(strobes), 4'd1);
    checkOutput("gap_key", seen, 4'b0001);
    applyStimulus(4'hF);
    quietSteps("gap_release", 12);
    applyStimulus(4'b1101);
    steps(6);
    checkOutput("repress_early", KEY, 4'h0);
    step();
    checkOutput("repress_key", KEY, 4'b0010);
    applyStimulus(4'hF);
    quietSteps("repress_release", 14);

    // Reset in the middle of the gap, with the key held across it.
    applyStimulus(4'b1110);
    steps(7);
    checkOutput("rgap_key", KEY, 4'b0001);
    steps(2);
    checkBit("rgap_busy_before", BUSY, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rgap_key0", KEY, 4'h0);
    checkBit("rgap_busy0", BUSY, 1'b0);
    checkBit("rgap_multi0", MULTI, 1'b0);
    @(negedge clock);
    @(negedge clock);
    checkBit("rgap_busy_hold", BUSY, 1'b0);
    reset = 1'b1;
    steps(6);
    checkOutput("rgap_early", KEY, 4'h0);
    step();
    checkOutput("rgap_restrobe", KEY, 4'b0001);
    applyStimulus(4'hF);
    quietSteps("rgap_release", 14);

    // Reset in the middle of a debounce. The pending press must be forgotten.
    applyStimulus(4'b0111);
    steps(4);
    #2 reset = 1'b0;
    #1;
    checkBit("rdeb_busy0", BUSY, 1'b0);
    applyStimulus(4'hF);
    @(negedge clock);
    reset = 1'b1;
    quietSteps("rdeb_after", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
